// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard and forwarding controller for a 5-stage MIPS pipeline.
// Shadows the EX/MEM destination info, drives operand forwarding and the load-use stall.
module id_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            dinstOut,
    input  logic                   regrt,
    input  logic                   wreg,
    input  logic                   m2reg,
    input  logic                   usesRs,
    input  logic                   usesRt,
    input  logic                   flush,
    output logic                   stall,
    output logic                   pcWrite,
    output logic                   ifidWrite,
    output logic [1:0]             fwdA,
    output logic [1:0]             fwdB,
    output logic [4:0]             edest,
    output logic [4:0]             mdest,
    output logic [STALL_CNT_W-1:0] stallCount
);

    typedef struct packed {
        logic [4:0] dest;
        logic       wr;
        logic       ld;
    } slot_t;

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,
        FWD_EX_ALU   = 2'b01,
        FWD_MEM_ALU  = 2'b10,
        FWD_MEM_LOAD = 2'b11
    } fwd_sel_e;

    localparam slot_t BUBBLE = '{dest: 5'd0, wr: 1'b0, ld: 1'b0};

    logic [4:0] rs;
    logic [4:0] rt;
    slot_t      id_slot;
    slot_t      ex_q;
    slot_t      mem_q;
    logic       ex_load_hits_rs;
    logic       ex_load_hits_rt;
    logic       unused_bits;

    assign rs          = dinstOut[25:21];
    assign rt          = dinstOut[20:16];
    assign unused_bits = ^{dinstOut[31:26], dinstOut[10:0]};

    assign id_slot.dest = regrt ? dinstOut[20:16] : dinstOut[15:11];
    assign id_slot.wr   = wreg;
    assign id_slot.ld   = m2reg;

    // Register 0 is hard-wired, so a producer targeting it is never a real dependency.
    function automatic logic writes_reg(input slot_t s, input logic [4:0] r);
        return s.wr && (s.dest != 5'd0) && (s.dest == r);
    endfunction

    // Youngest producer wins; an EX load can't forward and falls through to MEM.
    function automatic fwd_sel_e fwd_select(input slot_t ex, input slot_t mem,
                                            input logic [4:0] src);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (writes_reg(ex, src) && !ex.ld)
            sel = FWD_EX_ALU;
        else if (writes_reg(mem, src))
            sel = mem.ld ? FWD_MEM_LOAD : FWD_MEM_ALU;
        return sel;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ex_load_hits_rs = 1'b0;
        ex_load_hits_rt = 1'b0;
        if (ex_q.ld) begin
            ex_load_hits_rs = usesRs && writes_reg(ex_q, rs);
            ex_load_hits_rt = usesRt && writes_reg(ex_q, rt);
        end
    end

    assign stall     = ex_load_hits_rs || ex_load_hits_rt;
    assign pcWrite   = ~stall;
    assign ifidWrite = ~stall;

    assign fwdA  = fwd_select(ex_q, mem_q, rs);
    assign fwdB  = fwd_select(ex_q, mem_q, rt);
    assign edest = ex_q.dest;
    assign mdest = mem_q.dest;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
        end else begin
            mem_q <= ex_q;
            ex_q  <= (stall || flush) ? BUBBLE : id_slot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stallCount <= '0;
        else if (stall && (stallCount != {STALL_CNT_W{1'b1}}))
            stallCount <= stallCount + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: an in-flight instruction model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_id_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   dinstOut;
    logic          regrt, wreg, m2reg, usesRs, usesRt, flush;
    logic          stall, pcWrite, ifidWrite;
    logic [1:0]    fwdA, fwdB;
    logic [4:0]    edest, mdest;
    logic [CW-1:0] stallCount;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    id_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .dinstOut(dinstOut), .regrt(regrt), .wreg(wreg),
        .m2reg(m2reg), .usesRs(usesRs), .usesRt(usesRt), .flush(flush),
        .stall(stall), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
        .fwdA(fwdA), .fwdB(fwdB), .edest(edest), .mdest(mdest), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instructions currently in flight, youngest (EX) first.
    typedef struct {
        int  dest;
        bit  writes;
        bit  is_load;
    } instr_t;

    instr_t inflight[2];
    int     m_count;

    function automatic int f_rs();  return int'(dinstOut[25:21]); endfunction
    function automatic int f_rt();  return int'(dinstOut[20:16]); endfunction

    function automatic bit m_stall();
        instr_t p;
        p = inflight[0];
        if (!(p.writes && p.is_load && p.dest != 0)) return 1'b0;
        return (usesRs && p.dest == f_rs()) || (usesRt && p.dest == f_rt());
    endfunction

    // Source code: 0 regfile, 1 EX ALU, 2 MEM ALU, 3 MEM load.
    function automatic int m_fwd(input int r);
        if (r == 0) return 0;
        for (int age = 0; age < 2; age++) begin
            if (inflight[age].writes && inflight[age].dest == r) begin
                if (age == 0 && !inflight[age].is_load) return 1;
                if (age == 1) return inflight[age].is_load ? 3 : 2;
            end
        end
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight[0] = '{0, 1'b0, 1'b0};
            inflight[1] = '{0, 1'b0, 1'b0};
            m_count     = 0;
        end else begin
            bit st;
            st = m_stall();
            inflight[1] = inflight[0];
            if (st || flush)
                inflight[0] = '{0, 1'b0, 1'b0};
            else
                inflight[0] = '{regrt ? f_rt() : int'(dinstOut[15:11]), wreg, m2reg};
            if (st && m_count < (1 << CW) - 1) m_count++;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            bit st;
            st = m_stall();
            check("model stall", 32'(stall), 32'(st));
            check("model pcWrite", 32'(pcWrite), 32'(!st));
            check("model ifidWrite", 32'(ifidWrite), 32'(!st));
            check("model fwdA", 32'(fwdA), 32'(m_fwd(f_rs())));
            check("model fwdB", 32'(fwdB), 32'(m_fwd(f_rt())));
            check("model edest", 32'(edest), 32'(inflight[0].dest));
            check("model mdest", 32'(mdest), 32'(inflight[1].dest));
            check("model stallCount", 32'(stallCount), 32'(m_count));
        end
    end

    task automatic set_id(input int rs, input int rt, input int rd, input bit rrt,
                          input bit wr, input bit ld, input bit urs, input bit urt,
                          input bit fl);
        dinstOut = {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
        regrt = rrt; wreg = wr; m2reg = ld; usesRs = urs; usesRt = urt; flush = fl;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Leave the current ID instruction on the inputs to the midpoint, then clock it in.
    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop();
        reset = 1'b1;
        #12;
        check("reset stall", 32'(stall), 0);
        check("reset pcWrite", 32'(pcWrite), 1);
        check("reset fwdA", 32'(fwdA), 0);
        check("reset stallCount", 32'(stallCount), 0);
        @(negedge clk);
        reset = 1'b0;
        model_on = 1'b1;
        step();

        // EX then MEM ALU forwarding of $3
        set_id(1, 2, 3, 0, 1, 0, 1, 1, 0);
        step();
        set_id(3, 4, 8, 0, 1, 0, 1, 1, 0);
        to_mid();
        check("ex fwd fwdA", 32'(fwdA), 1);
        check("ex fwd stall", 32'(stall), 0);
        check("ex fwd edest", 32'(edest), 3);
        step();
        to_mid();
        check("mem fwd fwdA", 32'(fwdA), 2);
        step();

        // Load-use on $5
        set_id(1, 5, 0, 1, 1, 1, 1, 0, 0);
        step();
        set_id(6, 5, 10, 0, 1, 0, 1, 1, 0);
        to_mid();
        check("load-use stall", 32'(stall), 1);
        check("load-use pcWrite", 32'(pcWrite), 0);
        check("load-use ifidWrite", 32'(ifidWrite), 0);
        step();
        to_mid();
        check("after stall stall", 32'(stall), 0);
        check("after stall fwdB", 32'(fwdB), 3);
        check("after stall count", 32'(stallCount), 1);
        step();

        // Two producers of $7: EX wins
        set_id(1, 2, 7, 0, 1, 0, 1, 1, 0);
        step();
        set_id(2, 1, 7, 0, 1, 0, 1, 1, 0);
        step();
        set_id(7, 2, 11, 0, 1, 0, 1, 1, 0);
        to_mid();
        check("priority fwdA", 32'(fwdA), 1);
        check("priority mdest", 32'(mdest), 7);
        step();

        // Producers targeting $0, including a load
        set_id(1, 0, 0, 1, 1, 1, 1, 0, 0);
        step();
        set_id(0, 0, 0, 0, 1, 0, 1, 1, 0);
        to_mid();
        check("r0 stall", 32'(stall), 0);
        check("r0 fwdA", 32'(fwdA), 0);
        check("r0 fwdB", 32'(fwdB), 0);
        step();
        to_mid();
        check("r0 mem fwdB", 32'(fwdB), 0);
        step();

        // Flushed write of $9 never reaches EX
        set_id(1, 2, 9, 0, 1, 0, 1, 1, 1);
        step();
        set_id(9, 2, 12, 0, 1, 0, 1, 1, 0);
        to_mid();
        check("flush edest", 32'(edest), 0);
        check("flush fwdA", 32'(fwdA), 0);
        step();

        // Flush together with a load-use stall: still stalls and counts
        set_id(1, 11, 0, 1, 1, 1, 1, 0, 0);
        step();
        set_id(11, 2, 13, 0, 1, 0, 1, 1, 1);
        to_mid();
        check("flush+stall stall", 32'(stall), 1);
        step();
        to_mid();
        check("flush+stall count", 32'(stallCount), 2);
        check("flush+stall edest", 32'(edest), 0);
        step();

        // Twenty more load-use stalls saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_id(1, 14, 0, 1, 1, 1, 1, 0, 0);
            step();
            set_id(14, 2, 15, 0, 1, 0, 1, 1, 0);
            step();
            step();
        end
        to_mid();
        check("saturated count", 32'(stallCount), 15);
        step();

        // Reset while a load-use stall is active: clears without a clock edge
        set_id(1, 13, 0, 1, 1, 1, 1, 0, 0);
        step();
        set_id(13, 2, 16, 0, 1, 0, 1, 1, 0);
        to_mid();
        check("pre-reset stall", 32'(stall), 1);
        #1 reset = 1'b1;
        #1;
        check("async reset stall", 32'(stall), 0);
        check("async reset pcWrite", 32'(pcWrite), 1);
        check("async reset edest", 32'(edest), 0);
        check("async reset mdest", 32'(mdest), 0);
        check("async reset fwdA", 32'(fwdA), 0);
        check("async reset fwdB", 32'(fwdB), 0);
        check("async reset count", 32'(stallCount), 0);
        #1 reset = 1'b0;
        step();
        nop();
        step();
        to_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
